easyaxi_slv_rd: RTL



---
 rtl/easyaxi_slv_rd_pkg.sv | 44 ++++
 rtl/easyaxi_sync_fifo.sv | 58 +++++
 rtl/easyaxi_slv_rd.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/easyaxi_slv_rd_pkg.sv
// Shared definitions for the EasyAXI read-channel slave: bus widths,
// address limit, response codes and FSM state encoding.
// The `AXI_* widths keep their macro form so the master side can share them.
`ifndef EASYAXI_DEFINE_V
`define EASYAXI_DEFINE_V
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 16
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_SLV_ADDR_LIMIT
`define AXI_SLV_ADDR_LIMIT 16'h0001
`endif
`endif

package easyaxi_slv_rd_pkg;

  localparam int unsigned ID_W   = `AXI_ID_WIDTH;
  localparam int unsigned ADDR_W = `AXI_ADDR_WIDTH;
  localparam int unsigned DATA_W = `AXI_DATA_WIDTH;
  localparam int unsigned REQ_W  = ID_W + ADDR_W;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } rd_state_e;

  // R data for a normal response: zero-extended {arid, araddr}
  function automatic logic [DATA_W-1:0] rd_payload(input logic [ID_W-1:0]   id,
                                                   input logic [ADDR_W-1:0] addr);
    logic [REQ_W-1:0] req;
    req = {id, addr};
    return DATA_W'(req);
  endfunction

endpackage

// File: rtl/easyaxi_sync_fifo.sv
// Generic synchronous FIFO. Pointers carry one extra wrap bit; full when the
// address bits match and the wrap bits differ. Push into a full FIFO and pop
// from an empty FIFO are ignored.
module easyaxi_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // pointer advance
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // storage write, no reset needed
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/easyaxi_slv_rd.sv
// EasyAXI read-channel slave: buffers AR requests in order and answers each
// with a single-beat R response after RD_LATENCY wait cycles.
// Optional macro EASYAXI_SLV_DECERR_EN: addresses >= `AXI_SLV_ADDR_LIMIT get
// DECERR with zero data.
module easyaxi_slv_rd
  import easyaxi_slv_rd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       axi_slv_arvalid,
  output logic                       axi_slv_arready,
  input  logic [`AXI_ID_WIDTH-1:0]   axi_slv_arid,
  input  logic [`AXI_ADDR_WIDTH-1:0] axi_slv_araddr,
  output logic                       axi_slv_rvalid,
  input  logic                       axi_slv_rready,
  output logic [`AXI_ID_WIDTH-1:0]   axi_slv_rid,
  output logic [`AXI_DATA_WIDTH-1:0] axi_slv_rdata,
  output logic [1:0]                 axi_slv_rresp,
  output logic                       axi_slv_rlast
);

  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]  LAT_RELOAD = (RD_LATENCY == 0) ? 4'd0 : 4'(RD_LATENCY - 1);

  rd_state_e           state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                load;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REQ_W-1:0]    fifo_head;
  logic [CNT_W-1:0]    fifo_count;
  logic [ID_W-1:0]     head_id;
  logic [ADDR_W-1:0]   head_addr;
  logic                remain;

  assign axi_slv_arready = !fifo_full;
  assign fifo_push       = axi_slv_arvalid && !fifo_full;
  assign fifo_pop        = (state_q == ST_RESP) && axi_slv_rready;

  assign head_id   = fifo_head[REQ_W-1 -: ID_W];
  assign head_addr = fifo_head[ADDR_W-1:0];

  // entries left once the head is popped (a same-cycle push also counts)
  assign remain = (fifo_count != CNT_W'(1)) || fifo_push;

  easyaxi_sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .data_i  ({axi_slv_arid, axi_slv_araddr}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef EASYAXI_SLV_DECERR_EN
  logic head_decerr;
  assign head_decerr = (head_addr >= ADDR_W'(`AXI_SLV_ADDR_LIMIT));
`endif

  // next-state and latency counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (RD_LATENCY == 0) begin
            state_d = ST_RESP;
            load    = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_RELOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // with zero latency the next head is loaded via IDLE, since the
        // post-pop head is not visible until the pointer has moved
        if (axi_slv_rready) begin
          if (remain && (RD_LATENCY != 0)) begin
            state_d = ST_WAIT;
            cnt_d   = LAT_RELOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // R payload capture from FIFO head on entry to RESP
  always_comb begin
    rid_d   = rid_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (load) begin
      rid_d   = head_id;
      rdata_d = rd_payload(head_id, head_addr);
      rresp_d = AXI_RESP_OKAY;
`ifdef EASYAXI_SLV_DECERR_EN
      if (head_decerr) begin
        rdata_d = '0;
        rresp_d = AXI_RESP_DECERR;
      end
`endif
    end
  end

  // state, counter and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rid_q   <= '0;
      rdata_q <= '0;
      rresp_q <= AXI_RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rid_q   <= rid_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  assign axi_slv_rvalid = (state_q == ST_RESP);
  assign axi_slv_rid    = rid_q;
  assign axi_slv_rdata  = rdata_q;
  assign axi_slv_rresp  = rresp_q;
  assign axi_slv_rlast  = 1'b1;

endmodule
